// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory interface among NUM_PORTS cache requesters.
// Grant is registered, locked until the memory side pulses done, then one idle cycle follows.
module mem_port_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ID_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] request,
    input  logic                 done,
    output logic [NUM_PORTS-1:0] grant,
    output logic [ID_WIDTH-1:0]  grant_id,
    output logic                 busy
);

    typedef enum logic [0:0] {StIdle, StGranted} state_e;

    localparam logic [NUM_PORTS-1:0] OneHotZero = {{(NUM_PORTS-1){1'b0}}, 1'b1};
    localparam logic [ID_WIDTH-1:0]  LastReset  = ID_WIDTH'(NUM_PORTS - 1);

    state_e              state;
    logic [ID_WIDTH-1:0] last;

    logic                hi_hit;
    logic                lo_hit;
    logic [ID_WIDTH-1:0] hi_id;
    logic [ID_WIDTH-1:0] lo_id;
    logic                win_valid;
    logic [ID_WIDTH-1:0] win_id;

    // Round-robin: the lowest requester above last wins; otherwise wrap to the
    // lowest requester at or below last. Descending scan lets the lowest index win.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_id  = '0;
        lo_id  = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (request[i]) begin
                if (i > int'(last)) begin
                    hi_hit = 1'b1;
                    hi_id  = ID_WIDTH'(i);
                end else begin
                    lo_hit = 1'b1;
                    lo_id  = ID_WIDTH'(i);
                end
            end
        end
        win_valid = hi_hit | lo_hit;
        win_id    = hi_hit ? hi_id : lo_id;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= StIdle;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            last     <= LastReset;
        end else begin
            unique case (state)
                StIdle: begin
                    // done while idle belongs to no transaction and is dropped
                    if (win_valid) begin
                        state    <= StGranted;
                        grant    <= OneHotZero << win_id;
                        grant_id <= win_id;
                        busy     <= 1'b1;
                        last     <= win_id;
                    end
                end
                StGranted: begin
                    if (done) begin
                        state    <= StIdle;
                        grant    <= '0;
                        grant_id <= '0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= StIdle;
                    grant    <= '0;
                    grant_id <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    grant_onehot_a: assert property (@(posedge clock) disable iff (!reset) $onehot0(grant));
    busy_matches_a: assert property (@(posedge clock) disable iff (!reset) busy == (|grant));
    id_matches_a:   assert property (@(posedge clock) disable iff (!reset)
                                     grant == (busy ? (OneHotZero << grant_id) : '0));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with NUM_PORTS=4.
module tb_mem_port_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] request;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .NUM_PORTS(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .request  (request),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] req;
        logic       dn;
        logic [3:0] exp_grant;
        logic [1:0] exp_id;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eid,
                         input logic eb);
        checks++;
        if (grant !== eg || grant_id !== eid || busy !== eb) begin
            failures++;
            $display("FAIL %s: got grant=%b id=%0d busy=%b, expected grant=%b id=%0d busy=%b",
                     name, grant, grant_id, busy, eg, eid, eb);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        // Table starts idle with last=0 (left there by the fairness sequence).
        vecs[0]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
        vecs[1]  = '{4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1};
        vecs[2]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[3]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1};
        vecs[4]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
        vecs[7]  = '{4'b0010, 1'b0, 4'b0001, 2'd0, 1'b1};
        vecs[8]  = '{4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[10] = '{4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[11] = '{4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[12] = '{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1};
        vecs[13] = '{4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[14] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[15] = '{4'b0001, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[16] = '{4'b0001, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[17] = '{4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[18] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1};
        vecs[19] = '{4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[20] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};
        vecs[21] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[22] = '{4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1};
        vecs[23] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[24] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[25] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};

        reset   = 1'b0;
        request = 4'b1111;
        done    = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_hold", 4'b0000, 2'd0, 1'b0);

        reset = 1'b1;
        cycle();
        check("reset_release_grant0", 4'b0001, 2'd0, 1'b1);

        // Fairness: all requesting, done two cycles after each grant.
        for (int k = 0; k < 5; k++) begin
            logic [1:0] eid;
            eid = 2'(k % 4);
            check($sformatf("fair_grant%0d", k), 4'b0001 << eid, eid, 1'b1);
            cycle();
            check($sformatf("fair_hold%0d", k), 4'b0001 << eid, eid, 1'b1);
            done = 1'b1;
            cycle();
            done = 1'b0;
            check($sformatf("fair_idle%0d", k), 4'b0000, 2'd0, 1'b0);
            if (k < 4) cycle();
        end

        for (int i = 0; i < 26; i++) begin
            request = vecs[i].req;
            done    = vecs[i].dn;
            cycle();
            check($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_id, vecs[i].exp_busy);
        end
        done = 1'b0;

        // Asynchronous reset mid-grant: outputs must clear before any clock edge.
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_clear", 4'b0000, 2'd0, 1'b0);
        @(negedge clock);
        check("async_reset_held", 4'b0000, 2'd0, 1'b0);
        reset   = 1'b1;
        request = 4'b1000;
        cycle();
        check("post_reset_grant3", 4'b1000, 2'd3, 1'b1);

        // After reset last=3, so port 0 must beat port 3.
        reset = 1'b0;
        @(negedge clock);
        reset   = 1'b1;
        request = 4'b1001;
        cycle();
        check("post_reset_port0_first", 4'b0001, 2'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
